face_coords_tx: RTL

FACE_COORDS_TX -- requirements
Module: face_coords_tx

---
 rtl/face_coords_tx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/face_coords_tx.sv
// Face-detection coordinate transmitter.
// Buffers detections in a small FIFO and serialises each one as a 6-byte
// 8N1 UART packet: 0xA5, {4'h0, pyramid}, row[15:8], row[7:0], col[15:8], col[7:0].

module face_coords_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0][31:0] face_coords,
  input  logic            face_coords_ready,
  input  logic [3:0]      pyramid_number,
  output logic            uart_tx,
  output logic            tx_busy,
  output logic            overflow
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BYTE = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e       state;
  logic [35:0]  mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [35:0]  pkt;
  logic [2:0]   byte_idx;
  logic [2:0]   bit_cnt;
  logic [2:0]   next_bit;
  logic [15:0]  baud_cnt;
  logic [7:0]   cur_byte;
  logic [35:0]  new_entry;
  logic [35:0]  head_entry;

  logic fifo_empty;
  logic fifo_full;
  logic baud_done;
  logic last_byte;
  logic pop;
  logic push;
  logic drop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign last_byte  = (byte_idx == LAST_BYTE);
  assign next_bit   = bit_cnt + 3'd1;

  // A pop happens when idle, or at the very end of a packet's last stop bit.
  assign pop  = !fifo_empty &&
                ((state == StIdle) || ((state == StStop) && baud_done && last_byte));
  // A full FIFO still accepts an entry on the cycle its head is popped.
  assign push = face_coords_ready && (!fifo_full || pop);
  assign drop = face_coords_ready && fifo_full && !pop;

  // Only the low 16 bits of row/col are carried.
  assign new_entry  = {pyramid_number, face_coords[0][15:0], face_coords[1][15:0]};
  assign head_entry = mem[rd_ptr[AW-1:0]];

  assign tx_busy = (state != StIdle) || !fifo_empty;

  // Select the packet byte currently being serialised.
  always_comb begin
    cur_byte = 8'hA5;
    case (byte_idx)
      3'd0:    cur_byte = 8'hA5;
      3'd1:    cur_byte = {4'h0, pkt[35:32]};
      3'd2:    cur_byte = pkt[31:24];
      3'd3:    cur_byte = pkt[23:16];
      3'd4:    cur_byte = pkt[15:8];
      3'd5:    cur_byte = pkt[7:0];
      default: cur_byte = 8'h00;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clock) begin
    if (push && !reset) begin
      mem[wr_ptr[AW-1:0]] <= new_entry;
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // UART framing FSM; uart_tx is registered and always reflects the bit
  // currently on the line, so each transition loads the next bit's value.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= StIdle;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      pkt      <= '0;
    end else begin
      case (state)
        StIdle: begin
          uart_tx  <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            pkt      <= head_entry;
            byte_idx <= '0;
            uart_tx  <= 1'b0;
            state    <= StStart;
          end
        end

        StStart: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            uart_tx  <= cur_byte[0];
            state    <= StData;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        StData: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= StStop;
            end else begin
              bit_cnt <= next_bit;
              uart_tx <= cur_byte[next_bit];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        StStop: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (!last_byte) begin
              byte_idx <= byte_idx + 3'd1;
              uart_tx  <= 1'b0;
              state    <= StStart;
            end else if (pop) begin
              // Chain straight into the next packet with no idle gap.
              pkt      <= head_entry;
              byte_idx <= '0;
              uart_tx  <= 1'b0;
              state    <= StStart;
            end else begin
              uart_tx <= 1'b1;
              state   <= StIdle;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end

        default: begin
          uart_tx <= 1'b1;
          state   <= StIdle;
        end
      endcase
    end
  end

endmodule
